// File: rtl/rv_mem_reader.sv
// Purpose: drains {addr, len} bursts from a 1-cycle synchronous-read memory onto a ready/valid stream, flagging the final word.
// Latency: command handshake in cycle 0, mem_rd_en in cycle 1, output_port_valid in cycle 3; 1 word/cycle with ready held high.
// Backpressure: reads are credit-limited so buffered + in-flight words never exceed 3; nothing is lost or duplicated.
//
// Ports: clock_port/reset_port (async active-low); cmd_port_* command in; mem_addr/mem_rd_en/mem_data
// memory read port; output_port_* ready/valid stream out with last flag; busy high while a burst is active.
module rv_mem_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 10,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clock_port,
    input  logic                  reset_port,
    input  logic [ADDR_WIDTH-1:0] cmd_port_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_port_len,
    input  logic                  cmd_port_valid,
    output logic                  cmd_port_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] output_port_data,
    output logic                  output_port_valid,
    input  logic                  output_port_ready,
    output logic                  output_port_last,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic                  last;
    } entry_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] reads_left;   // reads still to issue after the most recently issued one
    logic                 rd_last;      // last flag travelling with the read currently on the memory port
    logic                 rd_pending;   // a read was issued last cycle; its data is on mem_data now
    logic                 pending_last;
    entry_t               entries [3];  // shift FIFO: entries[0] is always the head
    logic [1:0]           occ;

    logic                 pop;
    logic                 push;
    logic                 cmd_fire;
    logic [1:0]           wr_idx;
    logic [2:0]           committed_next;
    logic                 space_next;
    logic [ADDR_WIDTH-1:0] next_addr;
    entry_t               new_ent;

    assign output_port_valid = (occ != 2'd0);
    assign output_port_data  = entries[0].dat;
    assign output_port_last  = entries[0].last;
    assign cmd_port_ready    = (state == IDLE);
    assign busy              = (state != IDLE);

    always_comb begin
        pop      = output_port_valid && output_port_ready;
        push     = rd_pending;
        cmd_fire = cmd_port_valid && cmd_port_ready;
        // A push lands behind whatever survives this cycle's pop.
        wr_idx   = occ - {1'b0, pop};
        // Words buffered plus in flight as seen next cycle; a read may be
        // issued next cycle only if that total stays below the buffer depth.
        // Using the pop here (through a register) keeps full throughput
        // without any combinational path from ready to the memory port.
        committed_next = {1'b0, occ} + {2'b0, rd_pending} + {2'b0, mem_rd_en} - {2'b0, pop};
        space_next     = (committed_next < 3'd3);
        next_addr      = (mem_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : mem_addr + 1'b1;
        new_ent.dat    = mem_data;
        new_ent.last   = pending_last;
    end

    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            state        <= IDLE;
            mem_addr     <= '0;
            mem_rd_en    <= 1'b0;
            reads_left   <= '0;
            rd_last      <= 1'b0;
            rd_pending   <= 1'b0;
            pending_last <= 1'b0;
            occ          <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                entries[i] <= '0;
            end
        end else begin
            rd_pending   <= mem_rd_en;
            pending_last <= rd_last;
            occ          <= occ + {1'b0, push} - {1'b0, pop};

            entries[0] <= (push && wr_idx == 2'd0) ? new_ent : (pop ? entries[1] : entries[0]);
            entries[1] <= (push && wr_idx == 2'd1) ? new_ent : (pop ? entries[2] : entries[1]);
            entries[2] <= (push && wr_idx == 2'd2) ? new_ent : entries[2];

            case (state)
                IDLE: begin
                    // A zero-length command is consumed here and never leaves IDLE.
                    if (cmd_fire && cmd_port_len != '0) begin
                        state      <= READ;
                        mem_rd_en  <= 1'b1;
                        mem_addr   <= cmd_port_addr;
                        reads_left <= cmd_port_len - 1'b1;
                        rd_last    <= (cmd_port_len == LEN_WIDTH'(1));
                    end
                end
                READ: begin
                    if (mem_rd_en && reads_left == '0) begin
                        // Final read is on the port this cycle.
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                        rd_last   <= 1'b0;
                    end else if (space_next) begin
                        mem_rd_en  <= 1'b1;
                        mem_addr   <= next_addr;
                        reads_left <= reads_left - 1'b1;
                        rd_last    <= (reads_left == LEN_WIDTH'(1));
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (pop && output_port_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_reader.sv
// Purpose: self-checking bench for rv_mem_reader: directed corner cases, a vector table and random bursts.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Backpressure: output_port_ready is held, stalled or randomised per cycle depending on the test.
module tb_rv_mem_reader;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 10;
    localparam int LEN_WIDTH  = 5;

    logic                  clock_port = 1'b0;
    logic                  reset_port;
    logic [ADDR_WIDTH-1:0] cmd_port_addr;
    logic [LEN_WIDTH-1:0]  cmd_port_len;
    logic                  cmd_port_valid;
    logic                  cmd_port_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] output_port_data;
    logic                  output_port_valid;
    logic                  output_port_ready;
    logic                  output_port_last;
    logic                  busy;

    rv_mem_reader #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clock_port       (clock_port),
        .reset_port       (reset_port),
        .cmd_port_addr    (cmd_port_addr),
        .cmd_port_len     (cmd_port_len),
        .cmd_port_valid   (cmd_port_valid),
        .cmd_port_ready   (cmd_port_ready),
        .mem_addr         (mem_addr),
        .mem_rd_en        (mem_rd_en),
        .mem_data         (mem_data),
        .output_port_data (output_port_data),
        .output_port_valid(output_port_valid),
        .output_port_ready(output_port_ready),
        .output_port_last (output_port_last),
        .busy             (busy)
    );

    always #5 clock_port = ~clock_port;

    // Synchronous-read memory: mem[i] = 0x10 + i.
    logic [DATA_WIDTH-1:0] mem_arr [16];
    always @(posedge clock_port) begin
        if (mem_rd_en) mem_data <= mem_arr[mem_addr];
    end

    typedef struct {
        int addr;
        int len;
        int pct;
        int exp_first;
        int exp_last;
        int exp_cnt;
    } vec_t;

    vec_t vecs [8];

    int   n_cmp = 0;
    int   n_err = 0;
    int   tot_rd = 0;
    int   tot_pop = 0;
    logic [8:0] exp_q [$];   // {last, data} expected on the stream
    int         addr_q [$];  // expected memory read addresses
    int         got_q [$];   // every word popped off the stream

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_word(input int a);
        return 8'(16 + (a % DEPTH));
    endfunction

    // Reference model: a command expands into its list of addresses and words.
    task automatic monitor();
        logic [8:0] e;
        if (cmd_port_valid && cmd_port_ready) begin
            for (int k = 0; k < int'(cmd_port_len); k++) begin
                exp_q.push_back({(k == int'(cmd_port_len) - 1), ref_word(int'(cmd_port_addr) + k)});
                addr_q.push_back((int'(cmd_port_addr) + k) % DEPTH);
            end
        end
        if (mem_rd_en) begin
            tot_rd++;
            check("rd_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            check("rd_window", 32'(tot_rd - tot_pop <= 3), 32'd1);
        end
        if (output_port_valid && output_port_ready) begin
            got_q.push_back(int'(output_port_data));
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", 32'(output_port_data), 32'(e[7:0]));
                check("out_last", 32'(output_port_last), 32'(e[8]));
            end
            tot_pop++;
        end
    endtask

    task automatic tick();
        @(negedge clock_port);
        if (reset_port) monitor();
        @(posedge clock_port);
        #1;
    endtask

    task automatic flush_model();
        exp_q.delete();
        addr_q.delete();
        got_q.delete();
        tot_rd  = 0;
        tot_pop = 0;
    endtask

    task automatic send_cmd(input int addr, input int len);
        cmd_port_valid = 1'b1;
        cmd_port_addr  = ADDR_WIDTH'(addr);
        cmd_port_len   = LEN_WIDTH'(len);
        check("cmd_ready_before", 32'(cmd_port_ready), 32'd1);
        tick();
        cmd_port_valid = 1'b0;
    endtask

    task automatic wait_idle(input int pct);
        int budget;
        budget = 3000;
        while (budget > 0) begin
            output_port_ready = ($urandom_range(0, 99) < pct);
            tick();
            budget--;
            if (cmd_port_ready && !output_port_valid && exp_q.size() == 0) break;
        end
        check("burst_done", 32'(exp_q.size()), 32'd0);
        check("idle_ready", 32'(cmd_port_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_port_ready), 32'd1);
        check({tag, "_valid"},     32'(output_port_valid), 32'd0);
        check({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_addr"},      32'(mem_addr), 32'd0);
        check({tag, "_data"},      32'(output_port_data), 32'd0);
        check({tag, "_last"},      32'(output_port_last), 32'd0);
    endtask

    initial begin
        int gbase;
        int budget;
        int len;

        vecs[0] = '{addr: 2, len: 4,  pct: 100, exp_first: 'h12, exp_last: 'h15, exp_cnt: 4};
        vecs[1] = '{addr: 8, len: 4,  pct: 100, exp_first: 'h18, exp_last: 'h11, exp_cnt: 4};
        vecs[2] = '{addr: 0, len: 8,  pct: 30,  exp_first: 'h10, exp_last: 'h17, exp_cnt: 8};
        vecs[3] = '{addr: 9, len: 1,  pct: 50,  exp_first: 'h19, exp_last: 'h19, exp_cnt: 1};
        vecs[4] = '{addr: 5, len: 10, pct: 70,  exp_first: 'h15, exp_last: 'h14, exp_cnt: 10};
        vecs[5] = '{addr: 0, len: 31, pct: 60,  exp_first: 'h10, exp_last: 'h10, exp_cnt: 31};
        vecs[6] = '{addr: 7, len: 0,  pct: 100, exp_first: 0,    exp_last: 0,    exp_cnt: 0};
        vecs[7] = '{addr: 6, len: 15, pct: 90,  exp_first: 'h16, exp_last: 'h10, exp_cnt: 15};

        for (int i = 0; i < 16; i++) mem_arr[i] = 8'(16 + i);
        mem_data          = '0;
        reset_port        = 1'b0;
        cmd_port_valid    = 1'b0;
        cmd_port_addr     = '0;
        cmd_port_len      = '0;
        output_port_ready = 1'b0;

        // Reset state, then an asynchronous reset while idle.
        repeat (3) tick();
        check_reset_outputs("rst");
        reset_port = 1'b1;
        repeat (2) tick();
        #2 reset_port = 1'b0;
        #1 check_reset_outputs("idle_rst");
        tick();
        reset_port = 1'b1;
        flush_model();
        tick();

        // Basic burst with exact cycle timing.
        output_port_ready = 1'b1;
        send_cmd(2, 4);
        check("c1_rd_en", 32'(mem_rd_en), 32'd1);
        check("c1_addr", 32'(mem_addr), 32'd2);
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_cmd_ready", 32'(cmd_port_ready), 32'd0);
        tick();
        check("c2_addr", 32'(mem_addr), 32'd3);
        check("c2_valid", 32'(output_port_valid), 32'd0);
        tick();
        check("c3_addr", 32'(mem_addr), 32'd4);
        check("c3_valid", 32'(output_port_valid), 32'd1);
        check("c3_data", 32'(output_port_data), 32'h12);
        tick();
        check("c4_addr", 32'(mem_addr), 32'd5);
        check("c4_data", 32'(output_port_data), 32'h13);
        check("c4_last", 32'(output_port_last), 32'd0);
        tick();
        check("c5_rd_en", 32'(mem_rd_en), 32'd0);
        check("c5_data", 32'(output_port_data), 32'h14);
        tick();
        check("c6_data", 32'(output_port_data), 32'h15);
        check("c6_last", 32'(output_port_last), 32'd1);
        tick();
        check("c7_cmd_ready", 32'(cmd_port_ready), 32'd1);
        check("c7_valid", 32'(output_port_valid), 32'd0);
        check("c7_busy", 32'(busy), 32'd0);

        // Backpressure: stall ready for 6 cycles after the first pop.
        flush_model();
        output_port_ready = 1'b1;
        send_cmd(0, 8);
        budget = 10;
        while (!output_port_valid && budget > 0) begin
            tick();
            budget--;
        end
        check("bp_first_valid", 32'(output_port_valid), 32'd1);
        tick();
        output_port_ready = 1'b0;
        repeat (5) tick();
        check("bp_rd_stalled", 32'(mem_rd_en), 32'd0);
        check("bp_buffered", 32'(tot_rd - tot_pop), 32'd3);
        check("bp_hold_data", 32'(output_port_data), 32'h11);
        tick();
        output_port_ready = 1'b1;
        budget = 30;
        while (tot_pop < 8 && budget > 0) begin
            check("bp_no_gap", 32'(output_port_valid), 32'd1);
            tick();
            budget--;
        end
        check("bp_words", 32'(tot_pop), 32'd8);
        check("bp_idle", 32'(cmd_port_ready), 32'd1);

        // Zero-length command: consumed, nothing happens.
        flush_model();
        send_cmd(5, 0);
        for (int c = 0; c < 4; c++) begin
            check("z_rd_en", 32'(mem_rd_en), 32'd0);
            check("z_valid", 32'(output_port_valid), 32'd0);
            check("z_busy", 32'(busy), 32'd0);
            check("z_cmd_ready", 32'(cmd_port_ready), 32'd1);
            tick();
        end
        check("z_reads", 32'(tot_rd), 32'd0);

        // Reset in the middle of a burst, then a clean short burst.
        flush_model();
        output_port_ready = 1'b1;
        send_cmd(0, 6);
        budget = 20;
        while (tot_pop < 2 && budget > 0) begin
            tick();
            budget--;
        end
        check("mr_popped", 32'(tot_pop), 32'd2);
        #2 reset_port = 1'b0;
        #1 check_reset_outputs("mid_rst");
        flush_model();
        tick();
        tick();
        reset_port = 1'b1;
        send_cmd(3, 2);
        wait_idle(100);
        repeat (4) begin
            check("mr_no_stale", 32'(output_port_valid), 32'd0);
            tick();
        end
        check("mr_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("mr_w0", 32'(got_q[0]), 32'h13);
            check("mr_w1", 32'(got_q[1]), 32'h14);
        end

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            gbase = got_q.size();
            send_cmd(vecs[v].addr, vecs[v].len);
            wait_idle(vecs[v].pct);
            check("tbl_cnt", 32'(got_q.size() - gbase), 32'(vecs[v].exp_cnt));
            if (vecs[v].exp_cnt > 0 && got_q.size() > gbase) begin
                check("tbl_first", 32'(got_q[gbase]), 32'(vecs[v].exp_first));
                check("tbl_last", 32'(got_q[got_q.size() - 1]), 32'(vecs[v].exp_last));
            end
        end

        // Randomised bursts against the model.
        for (int r = 0; r < 40; r++) begin
            len   = int'($urandom_range(0, 31));
            gbase = got_q.size();
            send_cmd(int'($urandom_range(0, DEPTH - 1)), len);
            wait_idle(int'($urandom_range(20, 100)));
            check("rnd_cnt", 32'(got_q.size() - gbase), 32'(len));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
